// File: rtl/gray_code_counter_4bit.sv
// -----------------------------------------------------------------------------
// gray_code_counter_4bit
//
// Free-running reflected-binary (Gray) counter. The code advances by one step
// on every rising clock edge while reset is low and wraps modulo 2**WIDTH.
// Exactly one output bit changes per step, including at the wrap. This makes
// the output safe to sample from another clock domain.
//
// Ports
//   clk         in   1      Single clock; all state updates on the rising edge.
//   rst         in   1      Synchronous, active-high reset (clears the count).
//   o_gray_cnt  out  WIDTH  Current Gray code, driven directly from a register.
//
// Parameters
//   WIDTH       Counter width in bits (legal range 2..16); sequence length
//               2**WIDTH.
// -----------------------------------------------------------------------------
module gray_code_counter_4bit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] o_gray_cnt
);

    // A binary shadow count is kept alongside the Gray register. The next
    // Gray code is derived from the incremented binary value. It is then
    // registered, so the output never depends combinationally on any input
    // and never shows a multi-bit glitch.
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;

    localparam logic [WIDTH-1:0] BIN_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Binary to reflected-binary conversion.
    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Next-state computation: increment binary (natural wrap), encode to Gray.
    always_comb begin
        bin_d  = bin_q + BIN_ONE;
        gray_d = bin2gray(bin_d);
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    assign o_gray_cnt = gray_q;

endmodule

// File: tb/tb_gray_code_counter_4bit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_gray_code_counter_4bit
//
// Drives a WIDTH=4 and a WIDTH=6 instance from a shared clock and reset.
// Expected codes are pushed to a scoreboard queue when stimulus is applied,
// and they are popped and compared after the following rising edge.
// -----------------------------------------------------------------------------
module tb_gray_code_counter_4bit;

    logic       clk;
    logic       rst;
    logic [3:0] dout4;
    logic [5:0] dout6;

    gray_code_counter_4bit #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .o_gray_cnt (dout4)
    );

    gray_code_counter_4bit #(.WIDTH(6)) dut6 (
        .clk        (clk),
        .rst        (rst),
        .o_gray_cnt (dout6)
    );

    // 20 ns clock period.
    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct packed {
        logic [3:0] e4;
        logic [5:0] e6;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_bad    = 0;
    logic [3:0] m4       = 4'd0;
    logic [5:0] m6       = 6'd0;
    logic [3:0] prev4    = 4'd0;
    logic [5:0] prev6    = 6'd0;
    bit         prev_ok  = 1'b0;

    logic [3:0] seq_tbl [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                                 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                 4'b1011, 4'b1001, 4'b1000, 4'b0000};

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] gray2bin(input logic [15:0] g);
        logic [15:0] b;
        b[15] = g[15];
        for (int i = 14; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Apply one cycle of stimulus. Optionally pulse rst to the opposite level
    // and back between edges, which must not be seen by the DUT.
    task automatic step(input logic r, input bit glitch);
        exp_t e;
        @(negedge clk);
        rst = r;
        if (r) begin
            m4 = 4'd0;
            m6 = 6'd0;
        end else begin
            m4 = m4 + 4'd1;
            m6 = m6 + 6'd1;
        end
        e.e4 = m4 ^ (m4 >> 1);
        e.e6 = m6 ^ (m6 >> 1);
        exp_q.push_back(e);
        if (glitch) begin
            #3 rst = ~r;
            #3 rst = r;
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val("cnt4", {12'd0, dout4}, {12'd0, e.e4});
        check_val("cnt6", {10'd0, dout6}, {10'd0, e.e6});
        if (!r && prev_ok) begin
            check_val("ham4", 16'($countones(dout4 ^ prev4)), 16'd1);
            check_val("ham6", 16'($countones(dout6 ^ prev6)), 16'd1);
            check_val("dec4", gray2bin({12'd0, dout4}) & 16'h000F,
                      (gray2bin({12'd0, prev4}) + 16'd1) & 16'h000F);
            check_val("dec6", gray2bin({10'd0, dout6}) & 16'h003F,
                      (gray2bin({10'd0, prev6}) + 16'd1) & 16'h003F);
        end
        prev4   = dout4;
        prev6   = dout6;
        prev_ok = !r;
    endtask

    initial begin
        rst = 1'b1;

        // Long reset: output held at zero on every cycle.
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0);

        // First 16 codes after release, against the literal sequence.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0);
            check_val("seq", {12'd0, dout4}, {12'd0, seq_tbl[i]});
        end

        // Long free run: covers many 4-bit wraps and several 6-bit wraps.
        for (int i = 0; i < 1000; i++) step(1'b0, 1'b0);

        // Advance until the next code is 1101, then reset for one cycle.
        for (int i = 0; i < 16; i++) begin
            if (((m4 + 4'd1) ^ ((m4 + 4'd1) >> 1)) == 4'b1101) break;
            step(1'b0, 1'b0);
        end
        step(1'b0, 1'b0);
        check_val("pre_rst", {12'd0, dout4}, 16'h000D);
        step(1'b1, 1'b0);
        check_val("mid_rst", {12'd0, dout4}, 16'h0000);
        step(1'b0, 1'b0);
        check_val("restart", {12'd0, dout4}, 16'h0001);

        // Reset pulses that never cross a rising edge are ignored.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        // A low pulse inside a reset cycle also does not escape reset.
        step(1'b1, 1'b1);
        for (int i = 0; i < 70; i++) step(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
